// File: rtl/inst_encoder.sv
// inst_encoder
//   Turns a mnemonic code plus operand fields into 32-bit MIPS instruction
//   words with sequential word addresses. It expands the li pseudo-op into
//   one or two words. It sits in front of the instruction-memory loader.
//
// Handshake: an input request moves on a clock edge where in_valid && in_ready.
//   An output word moves on a clock edge where out_valid && out_ready.
//   While out_valid is high and out_ready is low, out_word and out_addr stay stable.
//   in_ready depends on the state register only.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid / in_ready   request handshake
//   mnem, rs, rt, rd,     mnemonic code and operand fields
//   shamt, imm, target
//   out_valid / out_ready encoded-word handshake
//   out_word, out_addr    encoded instruction and its word address
//   err                   one-cycle pulse when an illegal mnemonic is consumed
//   word_cnt              number of words the consumer has accepted (wraps)
//   dbgState              current FSM state (0 IDLE, 1 EMIT, 2 EMIT2)
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MNEM_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MNEM_W-1:0] mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [31:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [31:0]       out_addr,
  output logic              err,
  output logic [15:0]       word_cnt,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, EMIT2 = 2'd2} state_t;

  state_t      state;
  logic [31:0] pendWord;
  logic        pendValid;

  logic [31:0] code;
  logic [5:0]  fld;       // funct for R-type, opcode for I/J-type
  logic [4:0]  rsF, rtF, rdF, shF;
  logic [31:0] encWord, encWord2;
  logic        encTwo, encLegal;

  assign code = 32'(mnem);

  always_comb begin
    fld = 6'h00;
    case (code)
      32'd0:  fld = 6'h20;
      32'd1:  fld = 6'h21;
      32'd2:  fld = 6'h22;
      32'd3:  fld = 6'h23;
      32'd4:  fld = 6'h24;
      32'd5:  fld = 6'h25;
      32'd6:  fld = 6'h26;
      32'd7:  fld = 6'h27;
      32'd8:  fld = 6'h2a;
      32'd9:  fld = 6'h2b;
      32'd10: fld = 6'h00;
      32'd11: fld = 6'h02;
      32'd12: fld = 6'h03;
      32'd13: fld = 6'h08;
      32'd14: fld = 6'h09;
      32'd15: fld = 6'h23;
      32'd16: fld = 6'h2b;
      32'd17: fld = 6'h0f;
      32'd18: fld = 6'h08;
      32'd19: fld = 6'h09;
      32'd20: fld = 6'h0c;
      32'd21: fld = 6'h0d;
      32'd22: fld = 6'h0e;
      32'd23: fld = 6'h0a;
      32'd24: fld = 6'h0b;
      32'd25: fld = 6'h04;
      32'd26: fld = 6'h05;
      32'd27: fld = 6'h06;
      32'd28: fld = 6'h07;
      32'd29: fld = 6'h01;
      32'd30: fld = 6'h02;
      32'd31: fld = 6'h03;
      default: fld = 6'h00;
    endcase
  end

  always_comb begin
    encWord  = 32'h0;
    encWord2 = 32'h0;
    encTwo   = 1'b0;
    encLegal = 1'b1;
    rsF      = rs;
    rtF      = rt;
    rdF      = rd;
    shF      = 5'd0;
    if (code <= 32'd14) begin
      // Shifts carry shamt and have no rs; jr uses rs only.
      if (code >= 32'd10 && code <= 32'd12) begin
        rsF = 5'd0;
        shF = shamt;
      end
      if (code == 32'd13) begin
        rtF = 5'd0;
        rdF = 5'd0;
      end
      encWord = {6'h00, rsF, rtF, rdF, shF, fld};
    end else if (code <= 32'd29) begin
      if (code == 32'd17) rsF = 5'd0;   // lui
      if (code >= 32'd27) rtF = 5'd0;   // blez/bgtz/bltz
      encWord = {fld, rsF, rtF, imm[15:0]};
    end else if (code <= 32'd31) begin
      encWord = {fld, target};
    end else if (code == 32'd32) begin
      encWord = 32'h0;
    end else if (code == 32'd33) begin
      // li: if the upper half is zero, one ori is enough. Otherwise emit lui,
      // then an ori only when the lower half is nonzero.
      if (imm[31:16] == 16'h0) begin
        encWord = {6'h0d, 5'd0, rt, imm[15:0]};
      end else begin
        encWord  = {6'h0f, 5'd0, rt, imm[31:16]};
        encWord2 = {6'h0d, rt, rt, imm[15:0]};
        encTwo   = (imm[15:0] != 16'h0);
      end
    end else begin
      encLegal = 1'b0;
    end
  end

  assign in_ready = (state == IDLE);
  assign dbgState = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_word  <= 32'h0;
      out_addr  <= BASE_ADDR;
      err       <= 1'b0;
      word_cnt  <= 16'h0;
      pendWord  <= 32'h0;
      pendValid <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (encLegal) begin
              out_word  <= encWord;
              out_valid <= 1'b1;
              pendWord  <= encWord2;
              pendValid <= encTwo;
              state     <= EMIT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_addr <= out_addr + 32'd4;
            word_cnt <= word_cnt + 16'd1;
            if (pendValid) begin
              // The second li word follows with no bubble.
              out_word  <= pendWord;
              pendValid <= 1'b0;
              state     <= EMIT2;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        EMIT2: begin
          if (out_ready) begin
            out_addr  <= out_addr + 32'd4;
            word_cnt  <= word_cnt + 16'd1;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  mnem;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] word_cnt;
  logic [1:0]  dbgState;

  // clock / reset block
  always #5 clk = ~clk;

  inst_encoder #(.BASE_ADDR(BASE), .MNEM_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err(err),
    .word_cnt(word_cnt), .dbgState(dbgState)
  );

  // scoreboard: {addr, word}
  logic [63:0] exp_q[$];
  logic [31:0] expAddr;
  logic [15:0] expCnt;
  int nChecks = 0;
  int nFail   = 0;

  logic [5:0] functTab [0:14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
  logic [5:0] opTab [0:14] = '{6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e,
                               6'h0a, 6'h0b, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01};

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back({expAddr, w});
    expAddr = expAddr + 32'd4;
  endtask

  // Reference encoder: pushes the words a request should produce.
  task automatic model_push(input logic [5:0] m, input logic [4:0] s, t, d, sh,
                            input logic [31:0] im, input logic [25:0] tg, output int nw);
    int k;
    logic [4:0] s2, t2, d2, sh2;
    k = int'(m);
    nw = 0;
    if (k <= 14) begin
      s2  = (k >= 10 && k <= 12) ? 5'd0 : s;
      sh2 = (k >= 10 && k <= 12) ? sh : 5'd0;
      t2  = (k == 13) ? 5'd0 : t;
      d2  = (k == 13) ? 5'd0 : d;
      push_word({6'h00, s2, t2, d2, sh2, functTab[k]}); nw = 1;
    end else if (k <= 29) begin
      s2 = (k == 17) ? 5'd0 : s;
      t2 = (k >= 27) ? 5'd0 : t;
      push_word({opTab[k-15], s2, t2, im[15:0]}); nw = 1;
    end else if (k == 30) begin
      push_word({6'h02, tg}); nw = 1;
    end else if (k == 31) begin
      push_word({6'h03, tg}); nw = 1;
    end else if (k == 32) begin
      push_word(32'h0); nw = 1;
    end else if (k == 33) begin
      if (im[31:16] == 16'h0) begin
        push_word({6'h0d, 5'd0, t, im[15:0]}); nw = 1;
      end else begin
        push_word({6'h0f, 5'd0, t, im[31:16]}); nw = 1;
        if (im[15:0] != 16'h0) begin
          push_word({6'h0d, t, t, im[15:0]}); nw = 2;
        end
      end
    end
  endtask

  // driver: call at a negedge; returns just after the accepting posedge
  task automatic send_req(input logic [5:0] m, input logic [4:0] s, t, d, sh,
                          input logic [31:0] im, input logic [25:0] tg, output int nw);
    int waitC = 0;
    while (!in_ready && waitC < 50) begin
      @(negedge clk);
      waitC++;
    end
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFail++; $display("FAIL send_in_ready: got %b want 1", in_ready);
    end
    mnem = m; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
    in_valid = 1'b1;
    model_push(m, s, t, d, sh, im, tg, nw);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Output monitor: call at a negedge; consumes n words, comparing to the scoreboard.
  task automatic drain(input int n, input bit rnd, output int cyc, output logic [31:0] lastWord);
    int got = 0;
    logic [63:0] e;
    logic held = 1'b0;
    logic [31:0] heldWord = 32'h0, heldAddr = 32'h0;
    cyc = 0;
    lastWord = 32'h0;
    while (got < n && cyc < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held && out_valid) begin
        nChecks++;
        if (out_word !== heldWord || out_addr !== heldAddr) begin
          nFail++; $display("FAIL hold_stable: got %h@%h want %h@%h", out_word, out_addr, heldWord, heldAddr);
        end
      end
      if (out_valid) begin
        nChecks++;
        if (in_ready !== 1'b0) begin
          nFail++; $display("FAIL busy_in_ready: got %b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        nChecks++;
        if (exp_q.size() == 0) begin
          nFail++; $display("FAIL sb_empty: got word %h want none", out_word);
        end else begin
          e = exp_q.pop_front();
          if (out_word !== e[31:0] || out_addr !== e[63:32]) begin
            nFail++; $display("FAIL sb_word: got %h@%h want %h@%h", out_word, out_addr, e[31:0], e[63:32]);
          end
        end
        lastWord = out_word;
        expCnt = expCnt + 16'd1;
        got++;
      end
      held = out_valid && !out_ready;
      heldWord = out_word;
      heldAddr = out_addr;
      @(negedge clk);
      cyc++;
    end
    nChecks++;
    if (got != n) begin
      nFail++; $display("FAIL drain_timeout: got %0d words want %0d", got, n);
    end
    nChecks++;
    if (word_cnt !== expCnt) begin
      nFail++; $display("FAIL word_cnt: got %0d want %0d", word_cnt, expCnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mnem = 6'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; imm = 32'h0; target = 26'h0;
    exp_q.delete(); expAddr = BASE; expCnt = 16'h0;
    repeat (2) @(negedge clk);
    nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nChecks++; if (out_word !== 32'h0) begin nFail++; $display("FAIL reset_out_word: got %h want 0", out_word); end
    nChecks++; if (out_addr !== BASE) begin nFail++; $display("FAIL reset_out_addr: got %h want %h", out_addr, BASE); end
    nChecks++; if (err !== 1'b0) begin nFail++; $display("FAIL reset_err: got %b want 0", err); end
    nChecks++; if (word_cnt !== 16'h0) begin nFail++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    reset = 1'b0;
    @(negedge clk);
    nChecks++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    nChecks++; if (dbgState !== 2'd0) begin nFail++; $display("FAIL reset_state: got %0d want 0", dbgState); end
  endtask

  task automatic test_add();
    int nw, cyc;
    logic [31:0] lw;
    out_ready = 1'b0;
    send_req(6'd0, 5'd1, 5'd2, 5'd3, 5'd7, 32'h0, 26'h0, nw);
    @(negedge clk);
    nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("FAIL add_latency: got %b want 1", out_valid); end
    nChecks++; if (out_word !== 32'h00221820) begin nFail++; $display("FAIL add_word: got %h want 00221820", out_word); end
    nChecks++; if (out_addr !== 32'h0) begin nFail++; $display("FAIL add_addr: got %h want 0", out_addr); end
    drain(1, 1'b0, cyc, lw);
    nChecks++; if (word_cnt !== 16'd1) begin nFail++; $display("FAIL add_word_cnt: got %0d want 1", word_cnt); end
  endtask

  task automatic test_lw_j();
    int nw, cyc;
    logic [31:0] lw;
    send_req(6'd15, 5'd29, 5'd8, 5'd0, 5'd0, 32'hFFFFFFFC, 26'h0, nw);
    @(negedge clk);
    drain(1, 1'b0, cyc, lw);
    nChecks++; if (lw !== 32'h8FA8FFFC) begin nFail++; $display("FAIL lw_word: got %h want 8FA8FFFC", lw); end
    send_req(6'd30, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0100000, nw);
    @(negedge clk);
    drain(1, 1'b0, cyc, lw);
    nChecks++; if (lw !== 32'h08100000) begin nFail++; $display("FAIL j_word: got %h want 08100000", lw); end
  endtask

  task automatic test_li();
    int nw, cyc;
    logic [31:0] lw;
    send_req(6'd33, 5'd0, 5'd4, 5'd0, 5'd0, 32'h12345678, 26'h0, nw);
    @(negedge clk);
    nChecks++; if (out_word !== 32'h3C041234) begin nFail++; $display("FAIL li_lui_word: got %h want 3C041234", out_word); end
    drain(2, 1'b0, cyc, lw);
    nChecks++; if (cyc != 2) begin nFail++; $display("FAIL li_back_to_back: got %0d cycles want 2", cyc); end
    nChecks++; if (lw !== 32'h34845678) begin nFail++; $display("FAIL li_ori_word: got %h want 34845678", lw); end
    send_req(6'd33, 5'd0, 5'd4, 5'd0, 5'd0, 32'h00005678, 26'h0, nw);
    @(negedge clk);
    drain(1, 1'b0, cyc, lw);
    nChecks++; if (lw !== 32'h34045678) begin nFail++; $display("FAIL li_lo_word: got %h want 34045678", lw); end
    nChecks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nFail++; $display("FAIL li_lo_single: got valid %b ready %b want 0 1", out_valid, in_ready); end
    send_req(6'd33, 5'd0, 5'd4, 5'd0, 5'd0, 32'h00120000, 26'h0, nw);
    @(negedge clk);
    drain(1, 1'b0, cyc, lw);
    nChecks++; if (lw !== 32'h3C040012) begin nFail++; $display("FAIL li_hi_word: got %h want 3C040012", lw); end
    nChecks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nFail++; $display("FAIL li_hi_single: got valid %b ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    int nw, cyc;
    logic [31:0] lw, addr0;
    logic [15:0] cnt0;
    cnt0 = expCnt;
    out_ready = 1'b0;
    send_req(6'd10, 5'd9, 5'd2, 5'd3, 5'd4, 32'h0, 26'h0, nw);
    @(negedge clk);
    addr0 = out_addr;
    repeat (5) begin
      nChecks++;
      if (out_valid !== 1'b1 || out_word !== 32'h00021900 || out_addr !== addr0 || in_ready !== 1'b0) begin
        nFail++; $display("FAIL bp_hold: got v%b %h@%h r%b want v1 00021900@%h r0", out_valid, out_word, out_addr, in_ready, addr0);
      end
      @(negedge clk);
    end
    drain(1, 1'b0, cyc, lw);
    nChecks++; if (word_cnt !== cnt0 + 16'd1) begin nFail++; $display("FAIL bp_cnt: got %0d want %0d", word_cnt, cnt0 + 16'd1); end
  endtask

  task automatic test_illegal();
    int nw;
    logic [31:0] addr0;
    logic [15:0] cnt0;
    addr0 = expAddr; cnt0 = expCnt;
    out_ready = 1'b1;
    send_req(6'd63, 5'd1, 5'd1, 5'd1, 5'd1, 32'h1, 26'h1, nw);
    @(negedge clk);
    nChecks++; if (err !== 1'b1) begin nFail++; $display("FAIL ill_err_pulse: got %b want 1", err); end
    nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL ill_out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    nChecks++; if (err !== 1'b0) begin nFail++; $display("FAIL ill_err_width: got %b want 0", err); end
    nChecks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nFail++; $display("FAIL ill_idle: got ready %b valid %b want 1 0", in_ready, out_valid); end
    nChecks++; if (out_addr !== addr0 || word_cnt !== cnt0) begin nFail++; $display("FAIL ill_unchanged: got %h/%0d want %h/%0d", out_addr, word_cnt, addr0, cnt0); end
  endtask

  task automatic test_random();
    int nw, cyc;
    logic [31:0] lw;
    for (int i = 0; i < 24; i++) begin
      send_req(6'($urandom_range(0, 33)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               $urandom, 26'($urandom), nw);
      @(negedge clk);
      drain(nw, 1'b1, cyc, lw);
    end
  endtask

  task automatic test_reset_mid_li();
    int nw, cyc;
    logic [31:0] lw;
    logic [63:0] e;
    out_ready = 1'b1;
    send_req(6'd33, 5'd0, 5'd4, 5'd0, 5'd0, 32'h12345678, 26'h0, nw);
    @(negedge clk);
    e = exp_q.pop_front();
    nChecks++; if (out_word !== e[31:0]) begin nFail++; $display("FAIL rst_li_first: got %h want %h", out_word, e[31:0]); end
    @(negedge clk);
    out_ready = 1'b0;
    nChecks++; if (dbgState !== 2'd2 || out_valid !== 1'b1) begin nFail++; $display("FAIL rst_li_emit2: got state %0d valid %b want 2 1", dbgState, out_valid); end
    #2 reset = 1'b1;
    #1;
    nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    nChecks++; if (out_addr !== BASE || word_cnt !== 16'h0) begin nFail++; $display("FAIL rst_async_regs: got %h/%0d want %h/0", out_addr, word_cnt, BASE); end
    exp_q.delete(); expAddr = BASE; expCnt = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nChecks++; if (dbgState !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin nFail++; $display("FAIL rst_release: got state %0d ready %b valid %b want 0 1 0", dbgState, in_ready, out_valid); end
    // Encoding restarts from BASE with no leftover li word.
    send_req(6'd31, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h3ABCDEF, nw);
    @(negedge clk);
    drain(1, 1'b0, cyc, lw);
    nChecks++; if (lw !== 32'h0FABCDEF) begin nFail++; $display("FAIL jal_word: got %h want 0FABCDEF", lw); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_j();
    test_li();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid_li();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1);
  end

endmodule
